// File: rtl/zspi_pkg.sv
// Shared types and constants for the Z-controller SD-card SPI master.
package zspi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh
    } state_t;

    localparam int unsigned SPI_BITS = 8;
    localparam int unsigned BIT_W = $clog2(SPI_BITS);
    localparam logic IDLE_MOSI = 1'b1;
    localparam logic [SPI_BITS-1:0] RESET_DATA = 8'hFF;

endpackage

// File: rtl/zspi_clkgen.sv
// Half-period counter for the SPI clock: ticks when the count reaches zero and
// reloads from the divider latched at transfer start.
module zspi_clkgen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    output logic             tick
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            cnt <= '0;
        end else if (load) begin
            // A load on the final edge of a byte takes priority over the reload.
            div <= div_in;
            cnt <= div_in;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= div;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    assign tick = run && (cnt == '0);

endmodule

// File: rtl/zspi.sv
// SPI mode-0 master for the Z-controller SD path: one byte exchanged per start,
// with a one-deep holding register so back-to-back starts are not lost.
module zspi
    import zspi_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sd_start,
    input  logic [7:0]       sd_datain,
    input  logic [DIV_W-1:0] clk_div,
    output logic [7:0]       sd_dataout,
    output logic             busy,
    output logic             overrun,
    output logic             sdclk,
    output logic             sdo,
    input  logic             sdi
);

    state_t              state;
    logic [SPI_BITS-2:0] tx;
    logic [SPI_BITS-1:0] rx;
    logic [BIT_W-1:0]    bit_cnt;
    logic [7:0]          pend;
    logic                pend_v;

    logic                tick;
    logic                final_edge;
    logic                load;
    logic [7:0]          next_byte;

    zspi_clkgen #(
        .DIV_W(DIV_W)
    ) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state != StIdle),
        .load   (load),
        .div_in (clk_div),
        .tick   (tick)
    );

    always_comb begin
        final_edge = (state == StHigh) && tick && (bit_cnt == '0);
        load       = ((state == StIdle) && sd_start) || (final_edge && (pend_v || sd_start));
        next_byte  = pend_v ? pend : sd_datain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            tx         <= '0;
            rx         <= '0;
            bit_cnt    <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            sd_dataout <= RESET_DATA;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            sdclk      <= 1'b0;
            sdo        <= IDLE_MOSI;
        end else begin
            overrun <= 1'b0;

            case (state)
                StLow: begin
                    if (tick) begin
                        sdclk <= 1'b1;
                        rx    <= {rx[SPI_BITS-2:0], sdi};
                        state <= StHigh;
                    end
                end
                StHigh: begin
                    if (tick) begin
                        sdclk <= 1'b0;
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                            sdo     <= tx[SPI_BITS-2];
                            tx      <= {tx[SPI_BITS-3:0], 1'b0};
                            state   <= StLow;
                        end else begin
                            sd_dataout <= rx;
                            sdo        <= IDLE_MOSI;
                            busy       <= 1'b0;
                            state      <= StIdle;
                        end
                    end
                end
                StIdle: ;
                default: state <= StIdle;
            endcase

            // Overrides the drop to idle when another byte follows without a gap.
            if (load) begin
                tx      <= next_byte[SPI_BITS-2:0];
                sdo     <= next_byte[SPI_BITS-1];
                bit_cnt <= BIT_W'(SPI_BITS - 1);
                busy    <= 1'b1;
                state   <= StLow;
            end

            if (final_edge) begin
                if (sd_start) begin
                    pend <= sd_datain;
                end
                pend_v <= pend_v && sd_start;
            end else if (sd_start && (state != StIdle)) begin
                pend    <= sd_datain;
                pend_v  <= 1'b1;
                overrun <= pend_v;
            end
        end
    end

endmodule

// File: tb/tb_zspi.sv
// Bench for zspi: directed and randomized start schedules checked cycle by cycle
// against a transaction-level model of the SPI exchange.
module tb_zspi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sd_start;
    logic [7:0] sd_datain;
    logic [7:0] clk_div;
    logic [7:0] sd_dataout;
    logic       busy;
    logic       overrun;
    logic       sdclk;
    logic       sdo;
    logic       sdi;

    always #5 clk = ~clk;

    zspi #(
        .DIV_W(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sd_start   (sd_start),
        .sd_datain  (sd_datain),
        .clk_div    (clk_div),
        .sd_dataout (sd_dataout),
        .busy       (busy),
        .overrun    (overrun),
        .sdclk      (sdclk),
        .sdo        (sdo),
        .sdi        (sdi)
    );

    // Card side: either loop MOSI back or return miso_byte MSB-first.
    logic       loop_mode;
    logic [7:0] miso_byte;
    logic [2:0] wbits;
    logic [7:0] wshift;
    logic       prev_clk;
    assign sdi = loop_mode ? sdo : miso_byte[~wbits];

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_dout;
    logic [7:0] dut_wire[$];
    int         sch_at[$];
    logic [7:0] sch_val[$];
    bit         jitter;
    logic [7:0] base_div;
    int         last_ovr;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sched(input int at, input logic [7:0] val);
        sch_at.push_back(at);
        sch_val.push_back(val);
    endtask

    // Runs n cycles from an idle DUT, applying the schedule and comparing every
    // cycle against the model; when full, also checks the bytes seen on the wire.
    task automatic run(input string name, input int n, input bit full);
        int         e_busy, e_clk, e_sdo, e_dout, e_ovr, dut_ovr, idx;
        int         m_s, m_div, m_end, dv, ph, lim;
        bit         m_act, m_pv, st, go, x_ovr, x_clk, x_sdo;
        logic [7:0] m_pend, m_byte, din, nb;
        logic [7:0] exp_wire[$];
        e_busy = 0; e_clk = 0; e_sdo = 0; e_dout = 0; e_ovr = 0; dut_ovr = 0; idx = 0;
        m_act = 0; m_pv = 0; m_pend = 0; m_byte = 0; m_s = 0; m_div = 0; m_end = 0;
        dut_wire.delete();
        wbits = 0;
        wshift = 0;
        prev_clk = 0;
        for (int k = 0; k < n; k++) begin
            st = 0;
            din = 8'($urandom);
            if (idx < sch_at.size() && sch_at[idx] == k) begin
                st = 1;
                din = sch_val[idx];
                idx++;
            end
            clk_div = jitter ? 8'($urandom_range(0, 3)) : base_div;
            sd_start = st;
            sd_datain = din;
            dv = int'(clk_div);
            @(negedge clk);

            go = 0;
            x_ovr = 0;
            nb = din;
            if (m_act && k == m_end) begin
                exp_dout = loop_mode ? m_byte : miso_byte;
                if (m_pv || st) begin
                    nb = m_pv ? m_pend : din;
                    if (st) m_pend = din;
                    m_pv = m_pv && st;
                    go = 1;
                end else begin
                    m_act = 0;
                end
            end else if (!m_act && st) begin
                go = 1;
            end else if (m_act && st) begin
                x_ovr = m_pv;
                m_pend = din;
                m_pv = 1;
            end
            if (go) begin
                m_act = 1;
                m_s = k;
                m_byte = nb;
                m_div = dv;
                m_end = k + 16 * (dv + 1);
                exp_wire.push_back(nb);
            end

            ph = k - m_s;
            x_clk = m_act && ((ph / (m_div + 1)) % 2 == 1);
            x_sdo = m_act ? m_byte[3'(7 - ph / (2 * (m_div + 1)))] : 1'b1;
            if (busy !== m_act) e_busy++;
            if (sdclk !== x_clk) e_clk++;
            if (sdo !== x_sdo) e_sdo++;
            if (sd_dataout !== exp_dout) e_dout++;
            if (overrun !== x_ovr) e_ovr++;
            if (overrun === 1'b1) dut_ovr++;

            if (sdclk === 1'b1 && prev_clk == 1'b0) begin
                wshift = {wshift[6:0], sdo};
                if (wbits == 3'd7) dut_wire.push_back(wshift);
                wbits = wbits + 3'd1;
            end
            prev_clk = sdclk;
        end
        sd_start = 0;
        sch_at.delete();
        sch_val.delete();
        check({name, ".busy_cycles_bad"}, e_busy, 0);
        check({name, ".sdclk_cycles_bad"}, e_clk, 0);
        check({name, ".sdo_cycles_bad"}, e_sdo, 0);
        check({name, ".dataout_cycles_bad"}, e_dout, 0);
        check({name, ".overrun_cycles_bad"}, e_ovr, 0);
        if (full) begin
            check({name, ".wire_bytes"}, dut_wire.size(), exp_wire.size());
            lim = (dut_wire.size() < exp_wire.size()) ? dut_wire.size() : exp_wire.size();
            for (int i = 0; i < lim; i++) begin
                check($sformatf("%s.wire[%0d]", name, i), int'(dut_wire[i]), int'(exp_wire[i]));
            end
        end
        last_ovr = dut_ovr;
    endtask

    initial begin
        int t;
        int nst;
        rst_n = 1'b0;
        sd_start = 1'b0;
        sd_datain = 8'h00;
        clk_div = 8'h00;
        loop_mode = 1'b1;
        miso_byte = 8'h00;
        jitter = 0;
        base_div = 8'd0;
        exp_dout = 8'hFF;
        wbits = 0;
        repeat (3) @(negedge clk);
        check("reset.dataout", int'(sd_dataout), 'hFF);
        check("reset.busy", int'(busy), 0);
        check("reset.overrun", int'(overrun), 0);
        check("reset.sdclk", int'(sdclk), 0);
        check("reset.sdo", int'(sdo), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Loopback of 0xA5 at the fastest rate.
        sched(0, 8'hA5);
        run("t1_a5", 20, 1);
        check("t1.dataout", int'(sd_dataout), 'hA5);

        // 0xFF out, 0x3C back from the card, four cycles per level.
        loop_mode = 0;
        miso_byte = 8'h3C;
        base_div = 8'd3;
        sched(0, 8'hFF);
        run("t2_div3", 70, 1);
        check("t2.dataout", int'(sd_dataout), 'h3C);

        // Second start while busy is queued and follows with no gap.
        loop_mode = 1;
        base_div = 8'd0;
        sched(0, 8'h11);
        sched(5, 8'h22);
        run("t3_b2b", 36, 1);
        check("t3.overrun_pulses", last_ovr, 0);

        // Third start overwrites the pending byte.
        sched(0, 8'h11);
        sched(3, 8'h22);
        sched(6, 8'h33);
        run("t4_ovr", 36, 1);
        check("t4.overrun_pulses", last_ovr, 1);

        // Reset after three bits aborts at once.
        sched(0, 8'h96);
        run("t5_pre", 7, 0);
        rst_n = 1'b0;
        #1;
        check("t5.rst_sdclk", int'(sdclk), 0);
        check("t5.rst_sdo", int'(sdo), 1);
        check("t5.rst_busy", int'(busy), 0);
        check("t5.rst_dataout", int'(sd_dataout), 'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        exp_dout = 8'hFF;
        sched(1, 8'h5A);
        run("t5_post", 22, 1);

        // Starts landing exactly on final edges, pend empty then full.
        sched(0, 8'h40);
        sched(16, 8'h41);
        sched(20, 8'h42);
        sched(32, 8'h43);
        run("t6_final", 70, 1);
        check("t6.overrun_pulses", last_ovr, 0);

        // Random schedules, with clk_div wandering between starts on odd rounds.
        for (int r = 0; r < 8; r++) begin
            loop_mode = 1'($urandom);
            miso_byte = 8'($urandom);
            base_div = 8'($urandom_range(0, 3));
            jitter = (r % 2) == 1;
            nst = $urandom_range(1, 4);
            t = $urandom_range(0, 3);
            for (int i = 0; i < nst; i++) begin
                sched(t, 8'($urandom));
                t = t + $urandom_range(1, 40);
            end
            run($sformatf("rand%0d", r), t + 4 * 64 + 20, 1);
        end
        jitter = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
